// File: rtl/gcd_pkg.sv
// Shared types for the Stein GCD engine.
// State encoding and the cycle-counter width live here.
package gcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ZERO,
        FACTOR,
        STRIP,
        LOOP,
        DONE
    } gcd_state_t;

    localparam int CYC_W = 16;

endpackage

// File: rtl/gcd_stein_ctrl.sv
// Stein GCD sequencer: FSM only, drives datapath strobes.
// The datapath flags come from the top-level registers.
module gcd_stein_ctrl
    import gcd_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic out_ready,
    input  logic a_lsb,
    input  logic b_lsb,
    input  logic a_zero,
    input  logic b_zero,
    input  logic a_gt_b,
    output logic in_ready,
    output logic out_valid,
    output logic ld,
    output logic sh_ab,
    output logic sh_a,
    output logic sh_b,
    output logic swap_sub,
    output logic sub_b,
    output logic res_a,
    output logic res_b,
    output logic res_k,
    output logic busy
);

    gcd_state_t state, next;
    logic       alive;

    // alive keeps in_ready low until the first edge after reset drops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            alive <= 1'b0;
        end else begin
            state <= next;
            alive <= 1'b1;
        end
    end

    assign in_ready  = alive && (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == ZERO) || (state == FACTOR) ||
                       (state == STRIP) || (state == LOOP);

    always_comb begin
        next     = state;
        ld       = 1'b0;
        sh_ab    = 1'b0;
        sh_a     = 1'b0;
        sh_b     = 1'b0;
        swap_sub = 1'b0;
        sub_b    = 1'b0;
        res_a    = 1'b0;
        res_b    = 1'b0;
        res_k    = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    ld   = 1'b1;
                    next = ZERO;
                end
            end
            ZERO: begin
                if (a_zero) begin
                    res_b = 1'b1;
                    next  = DONE;
                end else if (b_zero) begin
                    res_a = 1'b1;
                    next  = DONE;
                end else begin
                    next = FACTOR;
                end
            end
            FACTOR: begin
                if (!a_lsb && !b_lsb) sh_ab = 1'b1;
                else                  next  = STRIP;
            end
            STRIP: begin
                if (!a_lsb) sh_a = 1'b1;
                else        next = LOOP;
            end
            LOOP: begin
                if (b_zero) begin
                    res_k = 1'b1;
                    next  = DONE;
                end else if (!b_lsb) begin
                    sh_b = 1'b1;
                end else if (a_gt_b) begin
                    swap_sub = 1'b1;
                end else begin
                    sub_b = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

endmodule

// File: rtl/gcd_stein.sv
// Binary (Stein) GCD engine with valid/ready on both sides.
// Define GCD_CYCLES_EN to add the saturating compute-cycle port.
module gcd_stein
    import gcd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
`ifdef GCD_CYCLES_EN
    ,
    output logic [CYC_W-1:0] cycles
`endif
);

    localparam int KW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a, b;
    logic [KW-1:0]    k;
    logic ld, sh_ab, sh_a, sh_b, swap_sub, sub_b;
    logic res_a, res_b, res_k, busy;

    gcd_stein_ctrl u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .out_ready(out_ready),
        .a_lsb    (a[0]),
        .b_lsb    (b[0]),
        .a_zero   (a == '0),
        .b_zero   (b == '0),
        .a_gt_b   (a > b),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .ld       (ld),
        .sh_ab    (sh_ab),
        .sh_a     (sh_a),
        .sh_b     (sh_b),
        .swap_sub (swap_sub),
        .sub_b    (sub_b),
        .res_a    (res_a),
        .res_b    (res_b),
        .res_k    (res_k),
        .busy     (busy)
    );

    // a stays odd in LOOP, so b-a and a-b never wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a      <= '0;
            b      <= '0;
            k      <= '0;
            result <= '0;
        end else begin
            if (ld) begin
                a <= a_in;
                b <= b_in;
                k <= '0;
            end
            if (sh_ab) begin
                a <= a >> 1;
                b <= b >> 1;
                k <= k + KW'(1);
            end
            if (sh_a) a <= a >> 1;
            if (sh_b) b <= b >> 1;
            if (swap_sub) begin
                a <= b;
                b <= a - b;
            end
            if (sub_b) b <= b - a;
            if (res_a) result <= a;
            if (res_b) result <= b;
            if (res_k) result <= a << k;
        end
    end

`ifdef GCD_CYCLES_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      cycles <= '0;
        else if (ld)                    cycles <= '0;
        else if (busy && cycles != '1)  cycles <= cycles + 1'b1;
    end
`endif

endmodule

// File: tb/tb_gcd_stein.sv
// Scoreboard bench for gcd_stein (WIDTH=32 plus a WIDTH=8 instance).
// Directed vectors; a negedge monitor pops and checks each result.
module tb_gcd_stein;

    typedef struct {
        logic [31:0] res;
        int          c0;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [15:0] cycles;

    logic        v8 = 1'b0;
    logic        rdy8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        ov8;
    logic        ordy8 = 1'b1;
    logic [7:0]  r8;
    logic [15:0] cyc8;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t cur;
    bit   active = 0;
    bit   have = 0;

    gcd_stein #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result)
`ifdef GCD_CYCLES_EN
        ,
        .cycles   (cycles)
`endif
    );

    gcd_stein #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (v8),
        .in_ready (rdy8),
        .a_in     (a8),
        .b_in     (b8),
        .out_valid(ov8),
        .out_ready(ordy8),
        .result   (r8)
`ifdef GCD_CYCLES_EN
        ,
        .cycles   (cyc8)
`endif
    );

`ifndef GCD_CYCLES_EN
    assign cycles = '0;
    assign cyc8   = '0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_le(input string name, input int got, input int lim);
        total++;
        if (got > lim) begin
            bad++;
            $display("FAIL %s got=%0d limit=%0d", name, got, lim);
        end
    endtask

    always @(negedge clk) begin
        int lat;
        if (out_valid) begin
            if (!active) begin
                active = 1;
                if (sb.size() == 0) begin
                    have = 0;
                    total++;
                    bad++;
                    $display("FAIL unexpected_result got=%0h", result);
                end else begin
                    have = 1;
                    cur  = sb.pop_front();
                    lat  = cyc - cur.c0 + 1;
                    chk("result", result, cur.res);
                    if (cur.lat != 0) chk("latency", lat, cur.lat);
                    chk_le("compute_bound", lat - 1, 6 * 32 + 4);
`ifdef GCD_CYCLES_EN
                    chk("cycles", {16'h0, cycles}, lat - 1);
`endif
                end
            end else if (have) begin
                chk("result_hold", result, cur.res);
            end
        end else begin
            active = 0;
        end
    end

    // called at a negedge; returns at the negedge after the accept edge
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat,
                        input bit track);
        int   n = 0;
        exp_t e;
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL accept_timeout got=0 exp=1");
        end else if (track) begin
            e.res = res;
            e.c0  = cyc + 1;
            e.lat = lat;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL idle_timeout got=%0d exp=0", sb.size());
        end
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_cycles", cycles, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);

        send(12, 18, 6, 10, 1);
        send(0, 35, 35, 2, 1);
        send(0, 0, 0, 2, 1);
        send(35, 0, 35, 2, 1);
        send(32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 0, 1);
        send(17, 17, 17, 0, 1);
        send(1, 32'hFFFF_FFFF, 1, 0, 1);
        wait_idle();

        // stall the consumer and poke in_valid while the result waits
        out_ready = 1'b0;
        send(48, 36, 12, 0, 1);
        n = 0;
        while (!out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("stall_out_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a_in     = 7;
            b_in     = 3;
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid_hold", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_after_hs", in_ready, 1);
        wait_idle();

        // abort a long LOOP phase with an asynchronous reset
        send(1071, 462, 21, 0, 0);
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_result", result, 0);
        chk("async_in_ready", in_ready, 0);
        chk("async_cycles", cycles, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(1071, 462, 21, 0, 1);
        wait_idle();

        v8 = 1'b1;
        a8 = 8'd255;
        b8 = 8'd85;
        n  = 0;
        while (!rdy8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        v8 = 1'b0;
        n  = 0;
        while (!ov8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("w8_out_valid", ov8, 1);
        chk("w8_result", r8, 85);
        chk_le("w8_bound", cyc8, 6 * 8 + 4);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
